ascon_input_masker: RTL and testbench
=====================================

// Module: ascon_input_masker
// PURPOSE
//  Upstream front-end of ascon_core_sca. Accepts unmasked key and bdi words plus bdi sideband,
//  splits each word into NUM_SHARES Boolean shares using fresh internal PRNG randomness, and
//  presents them on the core's shared key/bdi valid/ready ports. Each channel has one register stage.
// PARAMETERS
//  NUM_SHARES  2   number of Boolean shares (>=2)
//  CCW         32  bdi word width per share
//  CCSW        32  key word width per share
// PORTS
//  clk             in   1                  clock, all state on rising edge
//  rst             in   1                  asynchronous reset, active-low
//  seed            in   64                 PRNG seed
//  seed_valid      in   1                  load seed this cycle
//  seeded          out  1                  PRNG has been seeded since reset
//  key_u           in   CCSW               unmasked key word
//  key_u_valid     in   1                  key_u valid
//  key_u_ready     out  1                  key_u accepted when valid&ready
//  key             out  NUM_SHARES*CCSW    shared key to core (share i at [i*CCSW+:CCSW])
//  key_valid       out  1                  key valid
//  key_ready       in   1                  core accepts key
//  bdi_u           in   CCW                unmasked bdi word
//  bdi_u_valid     in   1                  bdi_u valid
//  bdi_u_ready     out  1                  bdi_u accepted when valid&ready
//  bdi_u_type      in   4                  D_* type, passed through
//  bdi_u_eot       in   1                  end of type, passed through
//  bdi_u_eoi       in   1                  end of input, passed through
//  bdi             out  NUM_SHARES*CCW     shared bdi to core
//  bdi_valid       out  1                  bdi valid
//  bdi_ready       in   1                  core accepts bdi
//  bdi_type        out  4                  registered bdi_u_type
//  bdi_eot         out  1                  registered bdi_u_eot
//  bdi_eoi         out  1                  registered bdi_u_eoi
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0 (bdi_type=D_NULL), PRNG state 0, seeded=0.
//  - PRNG: LANES=ceil(((NUM_SHARES-1)*(CCSW+CCW))/64) xorshift64 lanes (x^=x<<13; x^=x>>7; x^=x<<17).
//    All lanes step every cycle when seeded=1 and seed_valid=0, independent of handshakes.
//  - Seeding: seed_valid=1 loads lane i <= seed ^ (i*64'h9E3779B97F4A7C15); a result of 0 loads 64'h1.
//    seeded<=1 next cycle; reseed allowed anytime; held output registers are untouched.
//  - Random pool R = concatenated lane states; key uses R[0 +: (N-1)*CCSW], bdi uses the next
//    (N-1)*CCW bits, so both channels can accept in the same cycle with disjoint masks.
//  - Masking on accept: share i (i>=1) = its R slice; share 0 = word ^ XOR(shares 1..N-1).
//  - Channel handshake (key and bdi identical, independent):
//    in_ready = seeded & ~seed_valid & (~out_valid | out_ready).
//    Accept (in_valid&in_ready): capture shares+sideband, out_valid<=1. Latency 1 cycle.
//    out_valid&out_ready without accept: out_valid<=0. Simultaneous drain+accept: reload, stays 1.
//    Throughput 1 word/cycle/channel when downstream ready.
//  - Output data/sideband stable while out_valid=1 & out_ready=0; in_ready is combinational.
//  - Before seeding or during seed_valid, inputs are stalled; no unmasked word ever reaches outputs.
//  - Async reset mid-transfer: valids drop immediately; pending words discarded.
// STRUCTURE
//  - ascon_sca_pkg: NUM_SHARES, CCW, CCSW defaults, D_* type constants, XORSHIFT_GOLDEN constant.
//  - Sub-module ascon_xorshift64 (one lane: seed load, zero-fix, step enable), instantiated LANES times.
//  - Top: two identical channel register stages (generate or small function) + share XOR logic.
// TESTING
//  1. Reset, no seed, key_u_valid=1 key_u=32'hDEADBEEF -> key_u_ready=0, key_valid=0 for 10 cycles.
//  2. seed=64'h1, then key_u=32'hDEADBEEF -> next cycle key_valid=1, share0^share1=32'hDEADBEEF,
//     share1 = PRNG lane0 bits at accept cycle (matches reference xorshift model).
//  3. bdi stream 4 words, bdi_ready=0 for 3 cycles mid-stream -> bdi stable, bdi_u_ready=0;
//     release -> remaining words back-to-back, unmasked order and eot/eoi/type preserved.
//  4. seed=64'h0 -> lane0 loads 64'h1 (never all-zero); masks nonzero; two identical inputs on
//     consecutive cycles yield different share1 values.
//  5. Key and bdi accepted same cycle -> key share1 and bdi share1 taken from disjoint R bits.
//  6. rst asserted while bdi_valid=1 & bdi_ready=0 -> bdi_valid=0 immediately, seeded=0; reseed
//     required before next accept.

Source files
------------

// File: rtl/ascon_sca_pkg.sv
// ascon_sca_pkg: shared widths, bdi type codes and xorshift64 helpers for the masked Ascon front-end
package ascon_sca_pkg;

    localparam int NUM_SHARES_DEFAULT = 2;
    localparam int CCW_DEFAULT        = 32;
    localparam int CCSW_DEFAULT       = 32;

    localparam logic [3:0] D_NULL = 4'h0;
    localparam logic [3:0] D_AD   = 4'h1;
    localparam logic [3:0] D_MSG  = 4'h2;
    localparam logic [3:0] D_TAG  = 4'h3;
    localparam logic [3:0] D_HASH = 4'h4;

    localparam logic [63:0] XORSHIFT_GOLDEN = 64'h9E3779B97F4A7C15;

    function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

endpackage

// File: rtl/ascon_xorshift64.sv
// ascon_xorshift64: one xorshift64 PRNG lane with offset seed load and all-zero protection
module ascon_xorshift64
    import ascon_sca_pkg::*;
#(
    parameter logic [63:0] OFFSET = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] seed,
    input  logic        load,
    input  logic        en,
    output logic [63:0] state
);

    logic [63:0] seed_mix;

    assign seed_mix = seed ^ OFFSET;

    // Load a lane-specific seed (zero is replaced so the lane never locks up) or advance one step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= '0;
        else if (load)
            state <= (seed_mix == '0) ? 64'h1 : seed_mix;
        else if (en)
            state <= xorshift64_step(state);
    end

endmodule

// File: rtl/ascon_input_masker.sv
// ascon_input_masker: splits unmasked key/bdi words into Boolean shares behind one register stage each
module ascon_input_masker
    import ascon_sca_pkg::*;
#(
    parameter int NUM_SHARES = NUM_SHARES_DEFAULT,
    parameter int CCW        = CCW_DEFAULT,
    parameter int CCSW       = CCSW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [63:0]                seed,
    input  logic                       seed_valid,
    output logic                       seeded,
    input  logic [CCSW-1:0]            key_u,
    input  logic                       key_u_valid,
    output logic                       key_u_ready,
    output logic [NUM_SHARES*CCSW-1:0] key,
    output logic                       key_valid,
    input  logic                       key_ready,
    input  logic [CCW-1:0]             bdi_u,
    input  logic                       bdi_u_valid,
    output logic                       bdi_u_ready,
    input  logic [3:0]                 bdi_u_type,
    input  logic                       bdi_u_eot,
    input  logic                       bdi_u_eoi,
    output logic [NUM_SHARES*CCW-1:0]  bdi,
    output logic                       bdi_valid,
    input  logic                       bdi_ready,
    output logic [3:0]                 bdi_type,
    output logic                       bdi_eot,
    output logic                       bdi_eoi
);

    localparam int KEY_R = (NUM_SHARES - 1) * CCSW;
    localparam int BDI_R = (NUM_SHARES - 1) * CCW;
    localparam int LANES = (KEY_R + BDI_R + 63) / 64;

    logic [LANES*64-1:0]        pool;
    logic                       run;
    logic                       key_acc;
    logic                       bdi_acc;
    logic [NUM_SHARES*CCSW-1:0] key_m;
    logic [NUM_SHARES*CCW-1:0]  bdi_m;
    logic [CCSW-1:0]            key_s0;
    logic [CCW-1:0]             bdi_s0;

    assign run         = seeded & ~seed_valid;
    assign key_u_ready = run & (~key_valid | key_ready);
    assign bdi_u_ready = run & (~bdi_valid | bdi_ready);
    assign key_acc     = key_u_valid & key_u_ready;
    assign bdi_acc     = bdi_u_valid & bdi_u_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ascon_xorshift64 #(.OFFSET(XORSHIFT_GOLDEN * 64'(i))) u_lane (
            .clk   (clk),
            .rst   (rst),
            .seed  (seed),
            .load  (seed_valid),
            .en    (run),
            .state (pool[i*64 +: 64])
        );
    end

    // Shares 1..N-1 come straight from the pool (key low, bdi above it); share 0 absorbs the word
    always_comb begin
        key_m  = '0;
        bdi_m  = '0;
        key_s0 = key_u;
        bdi_s0 = bdi_u;
        for (int i = 1; i < NUM_SHARES; i++) begin
            key_m[i*CCSW +: CCSW] = pool[(i-1)*CCSW +: CCSW];
            bdi_m[i*CCW +: CCW]   = pool[KEY_R + (i-1)*CCW +: CCW];
            key_s0 = key_s0 ^ pool[(i-1)*CCSW +: CCSW];
            bdi_s0 = bdi_s0 ^ pool[KEY_R + (i-1)*CCW +: CCW];
        end
        key_m[CCSW-1:0] = key_s0;
        bdi_m[CCW-1:0]  = bdi_s0;
    end

    // Seeded flag stays set until the next reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            seeded <= 1'b0;
        else if (seed_valid)
            seeded <= 1'b1;
    end

    // Key stage: capture masked word on accept, drop valid once drained
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key       <= '0;
            key_valid <= 1'b0;
        end else if (key_acc) begin
            key       <= key_m;
            key_valid <= 1'b1;
        end else if (key_ready) begin
            key_valid <= 1'b0;
        end
    end

    // Bdi stage: same handshake as key, sideband travels with the shares
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bdi       <= '0;
            bdi_valid <= 1'b0;
            bdi_type  <= D_NULL;
            bdi_eot   <= 1'b0;
            bdi_eoi   <= 1'b0;
        end else if (bdi_acc) begin
            bdi       <= bdi_m;
            bdi_valid <= 1'b1;
            bdi_type  <= bdi_u_type;
            bdi_eot   <= bdi_u_eot;
            bdi_eoi   <= bdi_u_eoi;
        end else if (bdi_ready) begin
            bdi_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ascon_input_masker.sv
// tb_ascon_input_masker: seed/mask vector table, reference PRNG scoreboard and handshake corner cases
module tb_ascon_input_masker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] seed;
    logic        seed_valid;
    logic        seeded;
    logic [31:0] key_u;
    logic        key_u_valid;
    logic        key_u_ready;
    logic [63:0] key;
    logic        key_valid;
    logic        key_ready;
    logic [31:0] bdi_u;
    logic        bdi_u_valid;
    logic        bdi_u_ready;
    logic [3:0]  bdi_u_type;
    logic        bdi_u_eot;
    logic        bdi_u_eoi;
    logic [63:0] bdi;
    logic        bdi_valid;
    logic        bdi_ready;
    logic [3:0]  bdi_type;
    logic        bdi_eot;
    logic        bdi_eoi;

    always #5 clk = ~clk;

    ascon_input_masker dut (
        .clk         (clk),
        .rst         (rst),
        .seed        (seed),
        .seed_valid  (seed_valid),
        .seeded      (seeded),
        .key_u       (key_u),
        .key_u_valid (key_u_valid),
        .key_u_ready (key_u_ready),
        .key         (key),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .bdi_u       (bdi_u),
        .bdi_u_valid (bdi_u_valid),
        .bdi_u_ready (bdi_u_ready),
        .bdi_u_type  (bdi_u_type),
        .bdi_u_eot   (bdi_u_eot),
        .bdi_u_eoi   (bdi_u_eoi),
        .bdi         (bdi),
        .bdi_valid   (bdi_valid),
        .bdi_ready   (bdi_ready),
        .bdi_type    (bdi_type),
        .bdi_eot     (bdi_eot),
        .bdi_eoi     (bdi_eoi)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] mask;
        logic [3:0]  typ;
        logic        eot;
        logic        eoi;
    } exp_t;

    typedef struct {
        logic [63:0] seed;
        logic [31:0] key_w;
        logic [31:0] bdi_w;
        logic [31:0] key_mask;
        logic [31:0] bdi_mask;
    } seed_vec_t;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  typ;
        logic        eot;
        logic        eoi;
    } bdi_vec_t;

    exp_t        kq[$];
    exp_t        bq[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] m;
    logic        seeded_m, kv_m, bv_m, kr_m, br_m, hold;
    logic [69:0] prev_b;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_step(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        return y ^ (y << 17);
    endfunction

    // Reference model of PRNG, valids and readies; scoreboard pushes on accept, pops on drain
    always @(negedge clk) begin
        if (!rst) begin
            m = '0; seeded_m = 0; kv_m = 0; bv_m = 0; hold = 0;
            kq.delete(); bq.delete();
        end else begin
            kr_m = seeded_m & ~seed_valid & (~kv_m | key_ready);
            br_m = seeded_m & ~seed_valid & (~bv_m | bdi_ready);
            check("seeded", seeded, seeded_m);
            check("key_valid", key_valid, kv_m);
            check("bdi_valid", bdi_valid, bv_m);
            check("key_u_ready", key_u_ready, kr_m);
            check("bdi_u_ready", bdi_u_ready, br_m);
            if (hold) check("bdi_stable", {bdi, bdi_type, bdi_eot, bdi_eoi}, prev_b);
            hold   = bdi_valid & ~bdi_ready;
            prev_b = {bdi, bdi_type, bdi_eot, bdi_eoi};
            if (kv_m & key_ready) begin
                if (kq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL key_sb: got drain expected none");
                end else begin
                    e = kq.pop_front();
                    check("key_share1", key[63:32], e.mask);
                    check("key_unmasked", key[31:0] ^ key[63:32], e.word);
                end
            end
            if (bv_m & bdi_ready) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bdi_sb: got drain expected none");
                end else begin
                    e = bq.pop_front();
                    check("bdi_share1", bdi[63:32], e.mask);
                    check("bdi_unmasked", bdi[31:0] ^ bdi[63:32], e.word);
                    check("bdi_side", {bdi_type, bdi_eot, bdi_eoi}, {e.typ, e.eot, e.eoi});
                end
            end
            if (key_u_valid & kr_m) kq.push_back('{key_u, m[31:0], 4'h0, 1'b0, 1'b0});
            if (bdi_u_valid & br_m) bq.push_back('{bdi_u, m[63:32], bdi_u_type, bdi_u_eot, bdi_u_eoi});
            kv_m = (key_u_valid & kr_m) | (kv_m & ~key_ready);
            bv_m = (bdi_u_valid & br_m) | (bv_m & ~bdi_ready);
            if (seed_valid) begin
                m = (seed == 64'h0) ? 64'h1 : seed;
                seeded_m = 1;
            end else if (seeded_m) begin
                m = ref_step(m);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    seed_vec_t   sv[4];
    bdi_vec_t    bv[4];
    logic [31:0] a, b;
    int          n;

    initial begin
        sv[0] = '{64'h0000_0000_0000_0001, 32'hDEADBEEF, 32'h1111_2222, 32'h0000_0001, 32'h0000_0000};
        sv[1] = '{64'h0000_0000_0000_0000, 32'h0BAD_F00D, 32'h3333_4444, 32'h0000_0001, 32'h0000_0000};
        sv[2] = '{64'h0123_4567_89AB_CDEF, 32'hA5A5_5A5A, 32'h5555_6666, 32'h89AB_CDEF, 32'h0123_4567};
        sv[3] = '{64'hFFFF_0000_5555_AAAA, 32'h1234_5678, 32'h7777_8888, 32'h5555_AAAA, 32'hFFFF_0000};
        bv[0] = '{32'hA000_0001, 4'h1, 1'b0, 1'b0};
        bv[1] = '{32'hA000_0002, 4'h1, 1'b1, 1'b0};
        bv[2] = '{32'hB000_0003, 4'h2, 1'b0, 1'b0};
        bv[3] = '{32'hB000_0004, 4'h2, 1'b1, 1'b1};
        seed = '0; seed_valid = 0; key_u = '0; key_u_valid = 0; key_ready = 0;
        bdi_u = '0; bdi_u_valid = 0; bdi_u_type = '0; bdi_u_eot = 0; bdi_u_eoi = 0; bdi_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        check("rst_outputs", {key, bdi, key_valid, bdi_valid, seeded}, '0);
        check("rst_side", {bdi_type, bdi_eot, bdi_eoi}, '0);
        key_u = 32'hDEADBEEF; key_u_valid = 1; key_ready = 1;
        repeat (10) begin
            @(negedge clk);
            check("unseeded_ready", key_u_ready, 1'b0);
            check("unseeded_valid", key_valid, 1'b0);
        end
        @(posedge clk); #1 key_u_valid = 0; bdi_ready = 1;
        for (int i = 0; i < 4; i++) begin
            seed = sv[i].seed; seed_valid = 1;
            @(posedge clk); #1 seed_valid = 0;
            key_u = sv[i].key_w; key_u_valid = 1;
            bdi_u = sv[i].bdi_w; bdi_u_valid = 1; bdi_u_type = 4'h2;
            @(posedge clk); #1 key_u_valid = 0; bdi_u_valid = 0;
            check("vec_key_share1", key[63:32], sv[i].key_mask);
            check("vec_key_share0", key[31:0], sv[i].key_w ^ sv[i].key_mask);
            check("vec_bdi_share1", bdi[63:32], sv[i].bdi_mask);
            check("vec_bdi_share0", bdi[31:0], sv[i].bdi_w ^ sv[i].bdi_mask);
        end
        seed = 64'h0; seed_valid = 1;
        @(posedge clk); #1 seed_valid = 0; key_u = 32'hCAFEF00D; key_u_valid = 1;
        @(posedge clk); #1 a = key[63:32];
        @(posedge clk); #1 key_u_valid = 0; b = key[63:32];
        check("zero_seed_mask", a, 32'h1);
        check("mask_nonzero", b != 32'h0, 1'b1);
        check("mask_differs", a != b, 1'b1);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    bdi_u = bv[i].word; bdi_u_type = bv[i].typ;
                    bdi_u_eot = bv[i].eot; bdi_u_eoi = bv[i].eoi; bdi_u_valid = 1;
                    n = 0;
                    forever begin
                        @(negedge clk);
                        if (bdi_u_ready) break;
                        if (++n > 50) begin
                            checks++; errors++;
                            $display("FAIL stream_wait: got no ready expected ready");
                            break;
                        end
                    end
                    @(posedge clk); #1;
                end
                bdi_u_valid = 0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 bdi_ready = 0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_ready", bdi_u_ready, 1'b0);
                    check("stall_valid", bdi_valid, 1'b1);
                    @(posedge clk);
                end
                #1 bdi_ready = 1;
            end
        join
        repeat (3) @(posedge clk);
        #1 bdi_ready = 0; bdi_u = 32'h5A5A_0001; bdi_u_type = 4'h3; bdi_u_valid = 1;
        @(posedge clk); #1 bdi_u_valid = 0;
        #2 rst = 0;
        #1 check("async_rst", {bdi_valid, seeded, bdi_type}, '0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1; bdi_ready = 1; key_u = 32'h600D_CAFE; key_u_valid = 1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_ready", key_u_ready, 1'b0);
        end
        @(posedge clk); #1 seed = 64'h0042_0000_0000_0099; seed_valid = 1;
        @(posedge clk); #1 seed_valid = 0;
        @(negedge clk);
        check("reseed_ready", key_u_ready, 1'b1);
        @(posedge clk); #1 key_u_valid = 0;
        check("reseed_accept", key, {32'h0000_0099, 32'h600D_CAFE ^ 32'h0000_0099});
        repeat (3) @(posedge clk);
        #1 check("sb_empty", kq.size() + bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
